// File: rtl/rv_pkg.sv
// Shared RV32 definitions: XLEN, the RV32M funct3 operation encoding and the
// mul/div sequencer state encoding.
package rv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
      return -v;
   endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned radix-2 restoring divider datapath. load_i captures the operands,
// each step_i retires one quotient bit; quotient_o/remainder_o show the step result.
module muldiv_divider
   import rv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            last_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [4:0]      cnt_q, cnt_d;

   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;

   // Shifted remainder needs 33 bits; diff[XLEN] acts as the borrow of the trial subtract.
   always_comb begin
      shifted  = {rem_q, quo_q[XLEN-1]};
      diff     = shifted - {1'b0, dvs_q};
      rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], ~diff[XLEN]};
   end

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      if (load_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
         cnt_d = '0;
      end else if (step_i) begin
         rem_d = rem_next;
         quo_d = quo_next;
         cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign last_o      = (cnt_q == 5'd31);
   assign quotient_o  = quo_next;
   assign remainder_o = rem_next;

endmodule

// File: rtl/muldiv_unit.sv
// E-stage RV32M multiply/divide unit: single-cycle multiply and divide special
// cases, 32-cycle restoring divide, stall request while an operation is in flight.
module muldiv_unit
   import rv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] src_a_i,
   input  logic [XLEN-1:0] src_b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   muldiv_state_e   state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            rem_q, rem_d;
   logic            neg_q, neg_d;

   muldiv_op_e      op;
   logic            is_mul, is_rem, signed_div;
   logic            a_sgn, b_sgn;
   logic [63:0]     a_ext, b_ext, prod;
   logic [XLEN-1:0] mul_res;
   logic            div_by_zero, div_ovf;
   logic [XLEN-1:0] spec_res;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            neg_flag;

   logic            div_load, div_step, div_last;
   logic [XLEN-1:0] div_quo, div_rem, div_raw, div_res;

   assign op         = muldiv_op_e'(funct3_i);
   assign is_mul     = ~funct3_i[2];
   assign is_rem     = funct3_i[1];
   assign signed_div = (op == OP_DIV) || (op == OP_REM);

   // Operands are extended to 64 bits so one unsigned multiply covers all signedness mixes.
   always_comb begin
      a_sgn   = (op == OP_MULH) || (op == OP_MULHSU);
      b_sgn   = (op == OP_MULH);
      a_ext   = {{32{a_sgn & src_a_i[XLEN-1]}}, src_a_i};
      b_ext   = {{32{b_sgn & src_b_i[XLEN-1]}}, src_b_i};
      prod    = a_ext * b_ext;
      mul_res = (op == OP_MUL) ? prod[31:0] : prod[63:32];
   end

   always_comb begin
      div_by_zero = (src_b_i == '0);
      div_ovf     = signed_div && (src_a_i == 32'h8000_0000) && (src_b_i == '1);
      if (div_by_zero)
         spec_res = is_rem ? src_a_i : '1;
      else
         spec_res = is_rem ? '0 : 32'h8000_0000;
      a_abs    = (signed_div && src_a_i[XLEN-1]) ? twos_neg(src_a_i) : src_a_i;
      b_abs    = (signed_div && src_b_i[XLEN-1]) ? twos_neg(src_b_i) : src_b_i;
      neg_flag = is_rem ? (signed_div & src_a_i[XLEN-1])
                        : (signed_div & (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]));
   end

   assign div_raw = rem_q ? div_rem : div_quo;
   assign div_res = neg_q ? twos_neg(div_raw) : div_raw;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      div_load = 1'b0;
      div_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !flush_i) begin
               if (is_mul) begin
                  result_d = mul_res;
                  state_d  = ST_DONE;
               end else if (div_by_zero || div_ovf) begin
                  result_d = spec_res;
                  state_d  = ST_DONE;
               end else begin
                  div_load = 1'b1;
                  rem_d    = is_rem;
                  neg_d    = neg_flag;
                  state_d  = ST_DIV;
               end
            end
         end
         ST_DIV: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               div_step = 1'b1;
               if (div_last) begin
                  result_d = div_res;
                  state_d  = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         rem_q    <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
      end
   end

   muldiv_divider u_divider (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .load_i      (div_load),
      .step_i      (div_step),
      .dividend_i  (a_abs),
      .divisor_i   (b_abs),
      .last_o      (div_last),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   assign stall_o  = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_DIV);
   assign done_o   = (state_q == ST_DONE) && !flush_i;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: latency, stall window, special cases,
// flush, back-to-back issue and asynchronous reset.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_unit dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .start_i  (start),
      .funct3_i (funct3),
      .src_a_i  (src_a),
      .src_b_i  (src_b),
      .flush_i  (flush),
      .stall_o  (stall),
      .done_o   (done),
      .result_o (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at the start of cycle 0 (1 time unit after a rising edge); start is
   // held for cycle 0 only. Returns when done is seen or after 40 cycles.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output int last_stall,
                        output int done_cyc, output logic [31:0] res);
      n_stall    = 0;
      last_stall = -1;
      done_cyc   = -1;
      res        = 32'hxxxx_xxxx;
      start  = 1'b1;
      funct3 = f3;
      src_a  = a;
      src_b  = b;
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
         #2;
         if (stall) begin
            n_stall++;
            last_stall = c;
         end
         if (done) begin
            done_cyc = c;
            res      = result;
         end
         @(posedge clk); #1;
         if (c == 0) start = 1'b0;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int ns, ls, dc;
      logic [31:0] r;
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, ns, ls, dc, r);
      checks++; if (ns !== 1 || ls !== 0) begin errors++; $display("FAIL mulh_stall: got count %0d last %0d expected 1/0", ns, ls); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL mulh_latency: got %0d expected 1", dc); end
      checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_result: got %h expected 40000000", r); end
      #2;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mulh_done_pulse: got %b expected 0", done); end
      checks++; if (result !== 32'h4000_0000) begin errors++; $display("FAIL mulh_hold: got %h expected 40000000", result); end
      @(posedge clk); #1;
      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns, ls, dc, r);
      checks++; if (dc !== 1 || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu: got cyc %0d res %h expected 1/fffffffe", dc, r); end
      do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns, ls, dc, r);
      checks++; if (dc !== 1 || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu: got cyc %0d res %h expected 1/ffffffff", dc, r); end
      do_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, ns, ls, dc, r);
      checks++; if (dc !== 1 || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_low: got cyc %0d res %h expected 1/fffffffe", dc, r); end
   endtask

   task automatic test_div();
      int ns, ls, dc;
      logic [31:0] r;
      do_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, ns, ls, dc, r);
      checks++; if (ns !== 33 || ls !== 32) begin errors++; $display("FAIL div_stall: got count %0d last %0d expected 33/32", ns, ls); end
      checks++; if (dc !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", dc); end
      checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg: got %h expected fffffffd", r); end
      do_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, ns, ls, dc, r);
      checks++; if (dc !== 33 || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg: got cyc %0d res %h expected 33/ffffffff", dc, r); end
      do_op(3'b101, 32'd100, 32'd7, ns, ls, dc, r);
      checks++; if (dc !== 33 || r !== 32'd14) begin errors++; $display("FAIL divu: got cyc %0d res %h expected 33/0000000e", dc, r); end
      do_op(3'b111, 32'd100, 32'd7, ns, ls, dc, r);
      checks++; if (dc !== 33 || r !== 32'd2) begin errors++; $display("FAIL remu: got cyc %0d res %h expected 33/00000002", dc, r); end
   endtask

   task automatic test_special();
      int ns, ls, dc;
      logic [31:0] r;
      do_op(3'b100, 32'd5, 32'd0, ns, ls, dc, r);
      checks++; if (dc !== 1 || ns !== 1 || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: got cyc %0d stalls %0d res %h expected 1/1/ffffffff", dc, ns, r); end
      do_op(3'b111, 32'd5, 32'd0, ns, ls, dc, r);
      checks++; if (dc !== 1 || r !== 32'd5) begin errors++; $display("FAIL remu_by_zero: got cyc %0d res %h expected 1/00000005", dc, r); end
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, ns, ls, dc, r);
      checks++; if (dc !== 1 || r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf: got cyc %0d res %h expected 1/80000000", dc, r); end
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, ns, ls, dc, r);
      checks++; if (dc !== 1 || r !== 32'h0) begin errors++; $display("FAIL rem_ovf: got cyc %0d res %h expected 1/00000000", dc, r); end
   endtask

   task automatic test_flush();
      int ns, ls, dc, seen;
      logic [31:0] r;
      do_op(3'b000, 32'd2, 32'd5, ns, ls, dc, r);
      checks++; if (r !== 32'd10) begin errors++; $display("FAIL flush_pre_mul: got %h expected 0000000a", r); end
      start = 1'b1; funct3 = 3'b100; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      #2;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", done); end
      checks++; if (result !== 32'd10) begin errors++; $display("FAIL flush_result: got %h expected 0000000a", result); end
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #3;
         if (done || stall) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_quiet: got %0d active cycles expected 0", seen); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int dc, ns;
      logic [31:0] r;
      start = 1'b1; funct3 = 3'b000; src_a = 32'd3; src_b = 32'd4;
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_c0_stall: got %b expected 1", stall); end
      @(posedge clk); #1;
      #2;
      checks++; if (done !== 1'b1 || result !== 32'd12) begin errors++; $display("FAIL b2b_mul: got done %b res %h expected 1/0000000c", done, result); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b expected 0", stall); end
      @(posedge clk); #1;
      funct3 = 3'b101; src_a = 32'd9; src_b = 32'd3;
      #2;
      checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_c2: got stall %b done %b expected 1/0", stall, done); end
      @(posedge clk); #1;
      start = 1'b0;
      dc = -1; ns = 0; r = 32'h0;
      for (int c = 3; c < 45 && dc < 0; c++) begin
         #2;
         if (stall) ns++;
         if (done) begin dc = c; r = result; end
         @(posedge clk); #1;
      end
      checks++; if (dc !== 35 || r !== 32'd3) begin errors++; $display("FAIL b2b_divu: got cyc %0d res %h expected 35/00000003", dc, r); end
      checks++; if (ns !== 32) begin errors++; $display("FAIL b2b_div_stalls: got %0d expected 32", ns); end
      #2;
      checks++; if (done !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL b2b_after: got done %b stall %b expected 0/0", done, stall); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      int ns, ls, dc, seen;
      logic [31:0] r;
      do_op(3'b000, 32'd3, 32'd3, ns, ls, dc, r);
      checks++; if (r !== 32'd9) begin errors++; $display("FAIL rst_pre_mul: got %h expected 00000009", r); end
      start = 1'b1; funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_async_ctl: got stall %b done %b expected 0/0", stall, done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_async_result: got %h expected 00000000", result); end
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #3;
         if (done || stall) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles expected 0", seen); end
      @(posedge clk); #1;
      do_op(3'b000, 32'd6, 32'd7, ns, ls, dc, r);
      checks++; if (dc !== 1 || r !== 32'd42) begin errors++; $display("FAIL rst_fresh_mul: got cyc %0d res %h expected 1/0000002a", dc, r); end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      funct3 = 3'b000;
      src_a  = 32'h0;
      src_b  = 32'h0;
      flush  = 1'b0;
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
